// File: rtl/alu_seq_if.sv
// Handshake/result bundle between the control unit (master) and alu_seq_unit (slave).
// ALU_SEQ_REM_EN adds the rem_out result byte.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] alu_out;
  logic             save;
  logic             busy;
  logic             carry;
  logic             zero;
  logic             div_by_zero;
`ifdef ALU_SEQ_REM_EN
  logic [WIDTH-1:0] rem_out;

  modport master (
    output start, opcode, operand_a, operand_b,
    input  alu_out, save, busy, carry, zero, div_by_zero, rem_out
  );
  modport slave (
    input  start, opcode, operand_a, operand_b,
    output alu_out, save, busy, carry, zero, div_by_zero, rem_out
  );
`else
  modport master (
    output start, opcode, operand_a, operand_b,
    input  alu_out, save, busy, carry, zero, div_by_zero
  );
  modport slave (
    input  start, opcode, operand_a, operand_b,
    output alu_out, save, busy, carry, zero, div_by_zero
  );
`endif
endinterface

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: single-cycle logic/add ops, WIDTH-step shift-add MUL and restoring DIV.
// Optional macro ALU_SEQ_REM_EN adds rem_out (DIV remainder / MUL high byte).
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] alu_out_q;
  logic             save_q;
  logic             busy_q;
  logic             carry_q;
  logic             zero_q;
  logic             dz_q;
`ifdef ALU_SEQ_REM_EN
  logic [WIDTH-1:0] rem_q;
`endif

  // Returns {carry, result}; DIV here only ever means divide-by-zero.
  function automatic logic [WIDTH:0] simple_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SHL:  r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      OP_DIV:  r = {1'b0, {WIDTH{1'b1}}};
      default: r = '0;
    endcase
    return r;
  endfunction

  // One shift-add step on {hi, lo}; lo starts as the multiplier.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    return {sum[WIDTH:1], sum[0], lo[WIDTH-1:1]};
  endfunction

  // One restoring step on {rem, quo}; quo starts as the dividend.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_n;
    logic             q_bit;
    r_sh  = {rem, quo[WIDTH-1]};
    diff  = r_sh - {1'b0, dvs};
    q_bit = (r_sh >= {1'b0, dvs});
    rem_n = q_bit ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    return {rem_n, quo[WIDTH-2:0], q_bit};
  endfunction

  logic [2*WIDTH-1:0] step_nx;
  logic [WIDTH:0]     simple_res;

  always_comb begin
    step_nx = (op_q == OP_MUL) ? mul_step(hi_q, lo_q, opd_q)
                               : div_step(hi_q, lo_q, opd_q);
  end

  always_comb begin
    simple_res = simple_op(bus.opcode, bus.operand_a, bus.operand_b);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_q      <= '0;
      opd_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      alu_out_q <= '0;
      save_q    <= 1'b0;
      busy_q    <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      dz_q      <= 1'b0;
`ifdef ALU_SEQ_REM_EN
      rem_q     <= '0;
`endif
    end else begin
      save_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.opcode;
            cnt_q <= '0;
            if (bus.opcode == OP_MUL) begin
              opd_q  <= bus.operand_a;
              hi_q   <= '0;
              lo_q   <= bus.operand_b;
              busy_q <= 1'b1;
              state  <= EXEC;
            end else if (bus.opcode == OP_DIV && bus.operand_b != '0) begin
              opd_q  <= bus.operand_b;
              hi_q   <= '0;
              lo_q   <= bus.operand_a;
              busy_q <= 1'b1;
              state  <= EXEC;
            end else begin
              alu_out_q <= simple_res[WIDTH-1:0];
              carry_q   <= simple_res[WIDTH];
              zero_q    <= (simple_res[WIDTH-1:0] == '0);
              dz_q      <= (bus.opcode == OP_DIV);
`ifdef ALU_SEQ_REM_EN
              rem_q     <= (bus.opcode == OP_DIV) ? bus.operand_a : '0;
`endif
              save_q    <= 1'b1;
              busy_q    <= 1'b1;
              state     <= DONE;
            end
          end
        end
        EXEC: begin
          {hi_q, lo_q} <= step_nx;
          cnt_q        <= cnt_q + 1'b1;
          // Both MUL and DIV leave the result in the low half, the extra byte in the high half.
          if (cnt_q == CW'(WIDTH - 1)) begin
            alu_out_q <= step_nx[WIDTH-1:0];
            carry_q   <= (op_q == OP_MUL) && (step_nx[2*WIDTH-1:WIDTH] != '0);
            zero_q    <= (step_nx[WIDTH-1:0] == '0);
            dz_q      <= 1'b0;
`ifdef ALU_SEQ_REM_EN
            rem_q     <= step_nx[2*WIDTH-1:WIDTH];
`endif
            save_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_out     = alu_out_q;
  assign bus.save        = save_q;
  assign bus.busy        = busy_q;
  assign bus.carry       = carry_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dz_q;
`ifdef ALU_SEQ_REM_EN
  assign bus.rem_out     = rem_q;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed plan vectors, random ops against a
// plain-arithmetic model, ignored start, mid-operation reset and back-to-back issue.
module tb_alu_seq_unit;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq_unit #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       dz;
    logic [7:0] rem;
    int         lat;
  } vec_t;

  typedef struct {
    int         lat;
    int         busy_cnt;
    logic [7:0] res;
    logic [7:0] rem;
    logic       c;
    logic       z;
    logic       dz;
    logic       post_save;
    logic       post_busy;
  } obs_t;

  function automatic vec_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    int   ia;
    int   ib;
    int   p;
    ia = int'(a);
    ib = int'(b);
    v.op = op; v.a = a; v.b = b; v.c = 1'b0; v.dz = 1'b0; v.rem = 8'h00; v.lat = 1;
    case (op)
      3'd0: begin p = ia + ib; v.res = 8'(p % 256); v.c = (p > 255); end
      3'd1: begin p = ia - ib + 256; v.res = 8'(p % 256); v.c = (ia < ib); end
      3'd2: v.res = a & b;
      3'd3: v.res = a | b;
      3'd4: v.res = a ^ b;
      3'd5: begin p = ia * 2; v.res = 8'(p % 256); v.c = (ia >= 128); end
      3'd6: begin p = ia * ib; v.res = 8'(p % 256); v.c = (p > 255); v.rem = 8'(p / 256); v.lat = 9; end
      default: begin
        if (ib == 0) begin v.res = 8'hFF; v.dz = 1'b1; v.rem = a; end
        else begin v.res = 8'(ia / ib); v.rem = 8'(ia % ib); v.lat = 9; end
      end
    endcase
    v.z = (v.res == 8'h00);
    return v;
  endfunction

  // Issue one op and wait (bounded) for its save pulse, then one more edge.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output obs_t o);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    o.lat = 1; o.busy_cnt = 0;
    while (bus.save !== 1'b1 && o.lat < 30) begin
      if (bus.busy === 1'b1) o.busy_cnt++;
      @(posedge clk); #1;
      o.lat++;
    end
    if (bus.busy === 1'b1) o.busy_cnt++;
    o.res = bus.alu_out; o.c = bus.carry; o.z = bus.zero; o.dz = bus.div_by_zero;
`ifdef ALU_SEQ_REM_EN
    o.rem = bus.rem_out;
`else
    o.rem = 8'h00;
`endif
    @(posedge clk); #1;
    o.post_save = bus.save;
    o.post_busy = bus.busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0; bus.opcode = 3'd0; bus.operand_a = 8'h00; bus.operand_b = 8'h00;
    #12;
    checks++;
    if ({bus.alu_out, bus.save, bus.busy, bus.carry, bus.zero, bus.div_by_zero} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {bus.alu_out, bus.save, bus.busy, bus.carry, bus.zero, bus.div_by_zero});
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.save !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b save=%b exp 0 0", bus.busy, bus.save);
    end
  endtask

  task automatic test_directed();
    vec_t tbl[13];
    obs_t o;
    //           op    a      b      res    c     z     dz    rem    lat
    tbl[0]  = '{3'd0, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    tbl[1]  = '{3'd1, 8'd5,   8'd5,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[2]  = '{3'd1, 8'd3,   8'd4,   8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    tbl[3]  = '{3'd6, 8'd13,  8'd11,  8'h8F, 1'b0, 1'b0, 1'b0, 8'h00, 9};
    tbl[4]  = '{3'd6, 8'd20,  8'd20,  8'h90, 1'b1, 1'b0, 1'b0, 8'h01, 9};
    tbl[5]  = '{3'd7, 8'd200, 8'd7,   8'h1C, 1'b0, 1'b0, 1'b0, 8'h04, 9};
    tbl[6]  = '{3'd7, 8'd9,   8'd0,   8'hFF, 1'b0, 1'b0, 1'b1, 8'h09, 1};
    tbl[7]  = '{3'd0, 8'd1,   8'd2,   8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    tbl[8]  = '{3'd2, 8'hF0,  8'h3C,  8'h30, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    tbl[9]  = '{3'd3, 8'hF0,  8'h3C,  8'hFC, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    tbl[10] = '{3'd4, 8'hF0,  8'h3C,  8'hCC, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    tbl[11] = '{3'd5, 8'h81,  8'h00,  8'h02, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    tbl[12] = '{3'd7, 8'd5,   8'd9,   8'h00, 1'b0, 1'b1, 1'b0, 8'h05, 9};
    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, o);
      checks++;
      if (o.lat !== tbl[i].lat || o.busy_cnt !== tbl[i].lat) begin
        errors++;
        $display("FAIL dir%0d latency got %0d busy %0d exp %0d", i, o.lat, o.busy_cnt, tbl[i].lat);
      end
      checks++;
      if ({o.res, o.c, o.z, o.dz} !== {tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].dz}) begin
        errors++;
        $display("FAIL dir%0d result got %h c%b z%b dz%b exp %h c%b z%b dz%b", i,
                 o.res, o.c, o.z, o.dz, tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].dz);
      end
`ifdef ALU_SEQ_REM_EN
      checks++;
      if (o.rem !== tbl[i].rem) begin
        errors++;
        $display("FAIL dir%0d rem_out got %h exp %h", i, o.rem, tbl[i].rem);
      end
`endif
      checks++;
      if (o.post_save !== 1'b0 || o.post_busy !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d after_save save=%b busy=%b exp 0 0", i, o.post_save, o.post_busy);
      end
    end
  endtask

  task automatic test_random();
    vec_t e;
    obs_t o;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom_range(0, 255));
      b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      e  = model(op, a, b);
      run_op(op, a, b, o);
      checks++;
      if (o.lat !== e.lat || o.post_save !== 1'b0 || o.post_busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d timing op%0d lat %0d ps%b pb%b exp %0d 0 0", i, op, o.lat, o.post_save, o.post_busy, e.lat);
      end
      checks++;
      if ({o.res, o.c, o.z, o.dz} !== {e.res, e.c, e.z, e.dz}) begin
        errors++;
        $display("FAIL rnd%0d op%0d a=%h b=%h got %h c%b z%b dz%b exp %h c%b z%b dz%b", i, op, a, b,
                 o.res, o.c, o.z, o.dz, e.res, e.c, e.z, e.dz);
      end
`ifdef ALU_SEQ_REM_EN
      checks++;
      if (o.rem !== e.rem) begin
        errors++;
        $display("FAIL rnd%0d rem_out op%0d a=%h b=%h got %h exp %h", i, op, a, b, o.rem, e.rem);
      end
`endif
    end
  endtask

  task automatic test_ignore_start();
    int         saves;
    logic [7:0] res_at_save;
    logic       c_at_save;
    saves = 0; res_at_save = 8'h00; c_at_save = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 3'd6; bus.operand_a = 8'd13; bus.operand_b = 8'd11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc == 3) begin
        bus.start = 1'b1; bus.opcode = 3'd0; bus.operand_a = 8'd77; bus.operand_b = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.save === 1'b1) begin
        saves++; res_at_save = bus.alu_out; c_at_save = bus.carry;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (saves !== 1) begin
      errors++;
      $display("FAIL ignore_start save_count got %0d exp 1", saves);
    end
    checks++;
    if (res_at_save !== 8'h8F || c_at_save !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start result got %h c%b exp 8f c0", res_at_save, c_at_save);
    end
  endtask

  task automatic test_reset_mid();
    int   saves;
    obs_t o;
    saves = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 3'd7; bus.operand_a = 8'd200; bus.operand_b = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.alu_out, bus.save, bus.busy, bus.carry, bus.zero, bus.div_by_zero} !== 13'h0) begin
      errors++;
      $display("FAIL reset_mid outputs got %h exp 0", {bus.alu_out, bus.save, bus.busy, bus.carry, bus.zero, bus.div_by_zero});
    end
`ifdef ALU_SEQ_REM_EN
    checks++;
    if (bus.rem_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid rem_out got %h exp 00", bus.rem_out);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      if (bus.save === 1'b1 || bus.busy === 1'b1) saves++;
    end
    checks++;
    if (saves !== 0) begin
      errors++;
      $display("FAIL reset_mid stray_activity got %0d exp 0", saves);
    end
    run_op(3'd0, 8'd40, 8'd2, o);
    checks++;
    if (o.lat !== 1 || o.res !== 8'd42 || o.c !== 1'b0 || o.z !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid add_after got lat %0d %h c%b z%b exp 1 2a c0 z0", o.lat, o.res, o.c, o.z);
    end
  endtask

  task automatic test_back_to_back();
    vec_t e[5];
    for (int i = 0; i < 5; i++)
      e[i] = model(3'($urandom_range(0, 5)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = e[0].op; bus.operand_a = e[0].a; bus.operand_b = e[0].b;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        bus.opcode = e[i+1].op; bus.operand_a = e[i+1].a; bus.operand_b = e[i+1].b;
      end else begin
        bus.start = 1'b0;
      end
      checks++;
      if (bus.save !== 1'b1 || {bus.alu_out, bus.carry, bus.zero} !== {e[i].res, e[i].c, e[i].z}) begin
        errors++;
        $display("FAIL b2b%0d save=%b got %h c%b z%b exp save=1 %h c%b z%b", i, bus.save,
                 bus.alu_out, bus.carry, bus.zero, e[i].res, e[i].c, e[i].z);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.save !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d gap_save got %b exp 0", i, bus.save);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Multi-cycle 8-bit ALU that sits directly upstream of the accumulator/result register.
- Captures operands and opcode on a start strobe and computes the result: 1 cycle for simple ops, 8 iterative steps for MUL/DIV.
- Drives alu_out and a one-cycle save pulse that the downstream register uses to latch the result.
- Provides busy and status flags for the control unit.

Parameters:
- WIDTH, 8, operand/result width. Fixed at 8 for this CPU; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 DIV
- operand_a  in  8  first operand (dividend / multiplicand)
- operand_b  in  8  second operand (divisor / multiplier)
- alu_out  out  8  result; held between operations
- save  out  1  one-cycle strobe; result valid, downstream register latches
- busy  out  1  high whenever state is not IDLE
- carry  out  1  carry/borrow/overflow flag
- zero  out  1  alu_out == 0
- div_by_zero  out  1  last DIV had operand_b == 0

Behaviour:
- Reset (async, reset_n low): state IDLE; alu_out, save, busy, carry, zero, div_by_zero all 0; internal regs 0. Reset mid-operation aborts without emitting save.
- States: IDLE, EXEC, DONE.
- IDLE with start=1 at edge N: capture opcode and operands.
  - Simple ops and DIV with b=0: compute, load alu_out/flags, go to DONE at edge N.
  - MUL or DIV with b!=0: go to EXEC, step counter = 0.
- EXEC: one shift-add (MUL) or restoring shift-subtract (DIV) step per edge. After the 8th step (edge N+8), load result/flags and go to DONE.
- DONE: save=1 for exactly this one cycle; next edge returns to IDLE.
- Latency from start edge to save: 1 cycle for simple ops and DIV-by-zero, 9 cycles for MUL/DIV. Back-to-back throughput: one op per 2 cycles (simple ops).
- start while busy is ignored; operands are not re-sampled.
- Arithmetic: all results truncated to 8 bits.
  - ADD: carry = bit 8 of the sum.
  - SUB: a-b mod 256; carry = 1 when a < b (borrow).
  - AND/OR/XOR: carry = 0.
  - SHL: a<<1; carry = a[7].
  - MUL: alu_out = low byte of the product; carry = 1 if the high byte is nonzero.
  - DIV: alu_out = quotient, carry = 0. If b=0: alu_out = 8'hFF, div_by_zero = 1, carry = 0.
- div_by_zero is cleared by any non-DIV-by-zero completion.
- zero is computed from the final alu_out at completion.
- alu_out and flags update only at completion and hold until the next completion.

Optional Feature:
- Macro: ALU_SEQ_REM_EN
- Defined: extra output port rem_out (8).
  - DIV: remainder (DIV by zero: rem_out = operand_a).
  - MUL: high product byte.
  - Other ops: 0.
  - Updated at completion with alu_out; reset value 0.
- Undefined: port and its remainder/high-byte storage are absent. Core behaviour is identical.

Test Plan:
- Reset then ADD a=200 b=100 -> save pulses one cycle after the start edge; alu_out=0x2C, carry=1, zero=0, busy low two edges after start.
- SUB a=5 b=5 -> alu_out=0x00, zero=1, carry=0. SUB a=3 b=4 -> alu_out=0xFF, carry=1.
- MUL a=13 b=11 -> busy for 9 cycles, save at cycle 9, alu_out=0x8F, carry=0. MUL a=20 b=20 -> alu_out=0x90, carry=1 (rem_out=0x01 with ALU_SEQ_REM_EN).
- DIV a=200 b=7 -> save at cycle 9, alu_out=0x1C (rem_out=0x04 if enabled). DIV a=9 b=0 -> save after 1 cycle, alu_out=0xFF, div_by_zero=1. A following ADD clears div_by_zero.
- During MUL, pulse start with new operands at cycle 3 -> ignored; result still 0x8F, exactly one save pulse.
- Assert reset_n low at cycle 4 of DIV -> all outputs 0 immediately, no save pulse. A new ADD after release works normally.
